// File: rtl/ramio_arbiter_pkg.sv
// Shared types for the two-requester ramio arbiter.
package ramio_arbiter_pkg;

    localparam int unsigned NumReq = 2;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StRelease
    } state_e;

    typedef logic       req_idx_t;
    typedef logic [2:0] read_type_t;
    typedef logic [1:0] write_type_t;

    // A transaction with any read component waits for data; pure writes only wait for !busy.
    function automatic logic xfer_done(read_type_t rt, logic ready, logic busy);
        return (rt != '0) ? (ready && !busy) : !busy;
    endfunction

endpackage

// File: rtl/ramio_arbiter_rr.sv
// Combinational two-way round-robin pick: when both request, the one that was not last wins.
module ramio_arbiter_rr
    import ramio_arbiter_pkg::*;
(
    input  logic [NumReq-1:0] req_i,
    input  req_idx_t          last_i,
    output logic              valid_o,
    output req_idx_t          winner_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = (&req_i) ? ~last_i : req_i[1];
    end

endmodule

// File: rtl/ramio_arbiter.sv
// Shares the ramio client port between CPU (0) and DMA (1); optional watchdog under
// RAMIO_ARBITER_TIMEOUT_EN aborts a stuck transaction after TimeoutCycles ACTIVE cycles.
module ramio_arbiter
    import ramio_arbiter_pkg::*;
#(
    parameter int unsigned AddressBitWidth = 32,
    parameter int unsigned DataBitWidth    = 32,
    parameter int unsigned TimeoutCycles   = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NumReq-1:0]          req,
    input  logic [2:0]                 read_type0,
    input  logic [2:0]                 read_type1,
    input  logic [1:0]                 write_type0,
    input  logic [1:0]                 write_type1,
    input  logic [AddressBitWidth-1:0] address0,
    input  logic [AddressBitWidth-1:0] address1,
    input  logic [DataBitWidth-1:0]    data_in0,
    input  logic [DataBitWidth-1:0]    data_in1,
    output logic [NumReq-1:0]          gnt,
    output logic [NumReq-1:0]          done,
    output logic [NumReq-1:0]          error,
    output logic [DataBitWidth-1:0]    rd_data,
    output logic                       ram_enable,
    output logic [2:0]                 ram_read_type,
    output logic [1:0]                 ram_write_type,
    output logic [AddressBitWidth-1:0] ram_address,
    output logic [DataBitWidth-1:0]    ram_data_in,
    input  logic [DataBitWidth-1:0]    ram_data_out,
    input  logic                       ram_data_out_ready,
    input  logic                       ram_busy
);

    typedef struct packed {
        read_type_t                 read_type;
        write_type_t                write_type;
        logic [AddressBitWidth-1:0] address;
        logic [DataBitWidth-1:0]    data_in;
    } cmd_t;

    state_e                  state_q, state_d;
    req_idx_t                last_q, last_d;
    req_idx_t                owner_q, owner_d;
    cmd_t                    cmd_q, cmd_d;
    logic [NumReq-1:0]       gnt_q, gnt_d;
    logic [NumReq-1:0]       done_q, done_d;
    logic [DataBitWidth-1:0] rd_data_q, rd_data_d;
    logic                    pick_valid;
    req_idx_t                pick;

`ifdef RAMIO_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NumReq-1:0] error_q, error_d;
    assign error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TimeoutCycles;
    assign error = '0;
`endif

    ramio_arbiter_rr u_rr (
        .req_i    (req),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .winner_o (pick)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        cmd_d     = cmd_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        rd_data_d = rd_data_q;
`ifdef RAMIO_ARBITER_TIMEOUT_EN
        cnt_d     = cnt_q;
        error_d   = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d     = pick;
                    cmd_d       = pick ? cmd_t'{read_type1, write_type1, address1, data_in1}
                                       : cmd_t'{read_type0, write_type0, address0, data_in0};
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    state_d     = StActive;
`ifdef RAMIO_ARBITER_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            StActive: begin
                if (xfer_done(cmd_q.read_type, ram_data_out_ready, ram_busy)) begin
                    rd_data_d       = (cmd_q.read_type != '0) ? ram_data_out : '0;
                    last_d          = owner_q;
                    done_d[owner_q] = 1'b1;
                    state_d         = StRelease;
                end
`ifdef RAMIO_ARBITER_TIMEOUT_EN
                else if (cnt_q == CntMax) begin
                    rd_data_d        = '1;
                    last_d           = owner_q;
                    done_d[owner_q]  = 1'b1;
                    error_d[owner_q] = 1'b1;
                    state_d          = StRelease;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StRelease: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            cmd_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rd_data_q <= '0;
`ifdef RAMIO_ARBITER_TIMEOUT_EN
            cnt_q     <= '0;
            error_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
`ifdef RAMIO_ARBITER_TIMEOUT_EN
            cnt_q     <= cnt_d;
            error_q   <= error_d;
`endif
        end
    end

    always_comb begin
        ram_enable     = (state_q == StActive);
        ram_read_type  = ram_enable ? cmd_q.read_type  : '0;
        ram_write_type = ram_enable ? cmd_q.write_type : '0;
        ram_address    = ram_enable ? cmd_q.address    : '0;
        ram_data_in    = ram_enable ? cmd_q.data_in    : '0;
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_ramio_arbiter.sv
// Self-checking bench for ramio_arbiter: transaction-level model plus directed scenarios.
module tb_ramio_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = '0;
    logic [2:0]    read_type0 = '0, read_type1 = '0;
    logic [1:0]    write_type0 = '0, write_type1 = '0;
    logic [AW-1:0] address0 = '0, address1 = '0;
    logic [DW-1:0] data_in0 = '0, data_in1 = '0, ram_data_out = '0;
    logic          ram_data_out_ready = 1'b0, ram_busy = 1'b0;

    logic [1:0]    gnt, done, error;
    logic [DW-1:0] rd_data, ram_data_in;
    logic          ram_enable;
    logic [2:0]    ram_read_type;
    logic [1:0]    ram_write_type;
    logic [AW-1:0] ram_address;

    int n_checks = 0;
    int n_fail   = 0;

    ramio_arbiter #(
        .AddressBitWidth (AW),
        .DataBitWidth    (DW),
        .TimeoutCycles   (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (req),
        .read_type0         (read_type0),
        .read_type1         (read_type1),
        .write_type0        (write_type0),
        .write_type1        (write_type1),
        .address0           (address0),
        .address1           (address1),
        .data_in0           (data_in0),
        .data_in1           (data_in1),
        .gnt                (gnt),
        .done               (done),
        .error              (error),
        .rd_data            (rd_data),
        .ram_enable         (ram_enable),
        .ram_read_type      (ram_read_type),
        .ram_write_type     (ram_write_type),
        .ram_address        (ram_address),
        .ram_data_in        (ram_data_in),
        .ram_data_out       (ram_data_out),
        .ram_data_out_ready (ram_data_out_ready),
        .ram_busy           (ram_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who owns the port, whether it is in its done cycle,
    // and the command captured at grant time.
    int            m_owner = -1;
    bit            m_rel = 1'b0;
    bit            m_last = 1'b1;
    int            m_act = 0;
    logic [DW-1:0] m_rd = '0;
    logic [1:0]    m_err = '0;
    logic [2:0]    m_rt = '0;
    logic [1:0]    m_wt = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_rel = 1'b0; m_last = 1'b1; m_act = 0;
            m_rd = '0; m_err = '0; m_rt = '0; m_wt = '0; m_addr = '0; m_din = '0;
        end else if (m_owner < 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_owner = m_last ? 0 : 1;
                else              m_owner = req[1] ? 1 : 0;
                m_rt   = (m_owner == 1) ? read_type1  : read_type0;
                m_wt   = (m_owner == 1) ? write_type1 : write_type0;
                m_addr = (m_owner == 1) ? address1    : address0;
                m_din  = (m_owner == 1) ? data_in1    : data_in0;
                m_act  = 0;
            end
        end else if (!m_rel) begin
            m_act++;
            if ((m_rt != 0) ? (ram_data_out_ready && !ram_busy) : !ram_busy) begin
                m_rd   = (m_rt != 0) ? ram_data_out : '0;
                m_last = (m_owner == 1);
                m_rel  = 1'b1;
            end
`ifdef RAMIO_ARBITER_TIMEOUT_EN
            else if (m_act == TO) begin
                m_rd           = '1;
                m_err[m_owner] = 1'b1;
                m_last         = (m_owner == 1);
                m_rel          = 1'b1;
            end
`endif
        end else begin
            m_owner = -1;
            m_rel   = 1'b0;
            m_err   = '0;
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] eg;
        logic       en;
        eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        en = (m_owner >= 0) && !m_rel;
        check("gnt", gnt, eg);
        check("done", done, m_rel ? eg : 2'b00);
        check("error", error, m_rel ? m_err : 2'b00);
        check("rd_data", rd_data, m_rd);
        check("ram_enable", ram_enable, en);
        check("ram_read_type", ram_read_type, en ? m_rt : 3'b0);
        check("ram_write_type", ram_write_type, en ? m_wt : 2'b0);
        check("ram_address", ram_address, en ? m_addr : '0);
        check("ram_data_in", ram_data_in, en ? m_din : '0);
    end

    int         en_cnt, done_at, k;
    logic       err_at;
    logic [DW-1:0] rd_at;
    int         own_log[4];
    int         cyc_log[4];
    logic [DW-1:0] rd_log[4];
    int         exp_own[4] = '{0, 1, 0, 1};
    int         exp_cyc[4] = '{1, 4, 7, 10};

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset gnt", gnt, 2'b00);
        check("reset done", done, 2'b00);
        check("reset ram_enable", ram_enable, 1'b0);
        check("reset rd_data", rd_data, '0);
        rst_n = 1'b1;

        // Word write held off by busy for 4 ACTIVE cycles.
        req = 2'b01; write_type0 = 2'b10; address0 = 32'h100; data_in0 = 32'h1234_5678;
        ram_busy = 1'b1;
        en_cnt = 0; done_at = -1; err_at = 1'bx; rd_at = 'x;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) ram_busy = 1'b0;
            if (ram_enable) en_cnt++;
            if (done[0]) begin
                done_at = i; err_at = error[0]; rd_at = rd_data; req = 2'b00;
            end
        end
        check("write enable cycles", en_cnt, 5);
        check("write done cycle", done_at, 5);
        check("write error", err_at, 1'b0);
        check("write rd_data", rd_at, 32'h0);

        // Both reading from reset: strict alternation, one done every 3 cycles.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 2'b11; read_type0 = 3'b010; read_type1 = 3'b010; write_type0 = 2'b00;
        address1 = 32'h200; ram_data_out = 32'hCAFE_F00D; ram_data_out_ready = 1'b1;
        ram_busy = 1'b0;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done != 2'b00 && k < 4) begin
                own_log[k] = done[1] ? 1 : 0; cyc_log[k] = i; rd_log[k] = rd_data; k++;
            end
        end
        req = 2'b00;
        check("rr done count", k, 4);
        for (int j = 0; j < 4; j++) begin
            check("rr owner", own_log[j], exp_own[j]);
            check("rr done cycle", cyc_log[j], exp_cyc[j]);
            check("rr rd_data", rd_log[j], 32'hCAFE_F00D);
        end
        tick();

        // Address change while granted must not reach ramio.
        read_type1 = 3'b000; write_type1 = 2'b01; address1 = 32'h200; data_in1 = 32'h55;
        req = 2'b10; ram_busy = 1'b1;
        tick();
        address1 = 32'h300;
        tick();
        check("latched address", ram_address, 32'h200);
        ram_busy = 1'b0;
        tick();
        check("latched done", done, 2'b10);
        check("release address", ram_address, 32'h0);
        req = 2'b00;
        tick();

        // Reset mid-transaction.
        req = 2'b10; ram_busy = 1'b1;
        tick();
        check("pre-reset enable", ram_enable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset enable", ram_enable, 1'b0);
        check("async reset gnt", gnt, 2'b00);
        check("async reset done", done, 2'b00);
        tick();
        tick();
        rst_n = 1'b1;
        req = 2'b11; ram_busy = 1'b0;
        tick();
        check("post-reset winner", gnt, 2'b01);
        tick();
        check("post-reset done", done, 2'b01);
        req = 2'b00;
        tick();

`ifdef RAMIO_ARBITER_TIMEOUT_EN
        // Stuck busy: watchdog aborts after TO ACTIVE cycles.
        req = 2'b01; read_type0 = 3'b000; write_type0 = 2'b10; ram_busy = 1'b1;
        done_at = -1; err_at = 1'bx; rd_at = 'x;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done[0] && done_at < 0) begin
                done_at = i; err_at = error[0]; rd_at = rd_data; req = 2'b00;
            end
        end
        check("timeout done cycle", done_at, 8);
        check("timeout error", err_at, 1'b1);
        check("timeout rd_data", rd_at, 32'hFFFF_FFFF);
        ram_busy = 1'b0; req = 2'b01;
        tick();
        tick();
        check("after timeout done", done, 2'b01);
        check("after timeout error", error, 2'b00);
        req = 2'b00;
        tick();
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
